// File: rtl/dtc_pkg.sv
// dtc_pkg: shared constants and types for the CIC packet transmitter.
//
// Packet layout (bit 255 = MSB, transmitted LSB-first):
//   [255:248] sync word
//   [247:236] BX id
//   [235:232] number of filled stub slots (0..10)
//   [231:230] status (bit1 = backpressure seen in window, bit0 reserved)
//   [229:20]  ten 21-bit stub slots, slot k at [229-21k : 209-21k]
//   [19:0]    trailer (slot parity when CIC_TX_PARITY_EN is defined)
package dtc_pkg;

    localparam int PKT_W      = 256;
    localparam int STUB_W     = 21;
    localparam int N_SLOTS    = 10;
    localparam int HDR_MSB    = 255;
    localparam int SLOT0_MSB  = 229;
    localparam int TRAILER_W  = 20;
    localparam int CHIPID_OFS = 15;

    localparam int BX_W      = 12;
    localparam int SLOTCNT_W = 4;

    typedef struct packed {
        logic [2:0]  bx_ofs;
        logic [2:0]  chip_id;
        logic [14:0] payload;
    } stub_t;

    // MSB position of slot k inside the packet.
    function automatic int slot_msb(input int k);
        return SLOT0_MSB - STUB_W * k;
    endfunction

endpackage

// File: rtl/cic_tx_slot_buffer.sv
// cic_tx_slot_buffer: collects up to ten stubs per frame window.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   load          : high in the last cycle of the window (count == 255);
//                   the packet is captured from the current slot state and
//                   the buffer is refilled with FILL_WORD on the same edge
//   stub_data     : incoming stub word
//   stub_valid    : stub_data is valid
//   stub_ready    : a stub is accepted this cycle when valid is also high
//   slots         : the ten slot registers, slot 0 = first accepted stub
//   slot_cnt      : number of stubs accepted in this window (0..10)
//   backpressure  : a stub was refused somewhere in this window, including
//                   the current cycle
module cic_tx_slot_buffer
    import dtc_pkg::*;
#(
    parameter logic [STUB_W-1:0] FILL_WORD = 21'h1FFFFF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load,
    input  stub_t                           stub_data,
    input  logic                            stub_valid,
    output logic                            stub_ready,
    output logic [N_SLOTS-1:0][STUB_W-1:0]  slots,
    output logic [SLOTCNT_W-1:0]            slot_cnt,
    output logic                            backpressure
);

    logic accept;
    logic refused;
    logic bp_seen;

    // Ready is withheld in the load cycle so that no stub lands in a window
    // that is already being packed; a held stub simply waits for count 0.
    assign stub_ready   = !rst && (slot_cnt < SLOTCNT_W'(N_SLOTS)) && !load;
    assign accept       = stub_valid && stub_ready;
    assign refused      = stub_valid && !stub_ready;
    assign backpressure = bp_seen || refused;

    // Slot k is written only when it is the next free slot, so stubs beyond
    // the tenth are never written anywhere; they stay back-pressured.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            for (int k = 0; k < N_SLOTS; k++) begin
                slots[k] <= FILL_WORD;
            end
            slot_cnt <= '0;
            bp_seen  <= 1'b0;
        end else begin
            for (int k = 0; k < N_SLOTS; k++) begin
                if (accept && (slot_cnt == SLOTCNT_W'(k))) begin
                    slots[k] <= stub_data;
                end
            end
            if (accept) begin
                slot_cnt <= slot_cnt + SLOTCNT_W'(1);
            end
            if (refused) begin
                bp_seen <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cic_packet_tx.sv
// cic_packet_tx: assembles one 256-bit CIC packet per 256-cycle frame window
// and shifts it out LSB-first on a single serial line.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   stub_data   : 21-bit stub {bx_ofs[20:18], chip_id[17:15], payload[14:0]}
//   stub_valid  : stub_data is valid
//   stub_ready  : block accepts a stub this cycle
//   sdata       : registered serial packet stream, LSB-first
//   frame_start : high while packet bit 0 is on sdata
//   bx_id       : BX id of the packet currently on sdata
//
// Optional feature: define CIC_TX_PARITY_EN to place the even parity of each
// slot in trailer bit k; otherwise the trailer is all zeros.
module cic_packet_tx
    import dtc_pkg::*;
#(
    parameter logic [7:0]        SYNC_WORD = 8'hA5,
    parameter logic [STUB_W-1:0] FILL_WORD = 21'h1FFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STUB_W-1:0] stub_data,
    input  logic              stub_valid,
    output logic              stub_ready,
    output logic              sdata,
    output logic              frame_start,
    output logic [BX_W-1:0]   bx_id
);

    logic [7:0]                      count;
    logic                            load;
    logic [BX_W-1:0]                 bx_cnt;
    logic [BX_W-1:0]                 bx_loaded;
    logic                            primed;
    logic [PKT_W-1:0]                shreg;
    logic [PKT_W-1:0]                pkt;
    logic [N_SLOTS-1:0][STUB_W-1:0]  slots;
    logic [SLOTCNT_W-1:0]            slot_cnt;
    logic                            backpressure;

    assign load = (count == 8'hFF);

    cic_tx_slot_buffer #(
        .FILL_WORD (FILL_WORD)
    ) u_slots (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .stub_data    (stub_data),
        .stub_valid   (stub_valid),
        .stub_ready   (stub_ready),
        .slots        (slots),
        .slot_cnt     (slot_cnt),
        .backpressure (backpressure)
    );

    // Packet image built from the live slot state; it is only captured into
    // the shift register in the load cycle.
    always_comb begin
        pkt = '0;
        pkt[HDR_MSB -: 8]       = SYNC_WORD;
        pkt[HDR_MSB - 8 -: BX_W] = bx_cnt;
        pkt[235:232]            = slot_cnt;
        pkt[231]                = backpressure;
        pkt[230]                = 1'b0;
        for (int k = 0; k < N_SLOTS; k++) begin
            pkt[slot_msb(k) -: STUB_W] = slots[k];
        end
`ifdef CIC_TX_PARITY_EN
        pkt[TRAILER_W-1:N_SLOTS] = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            pkt[k] = ^slots[k];
        end
`else
        pkt[TRAILER_W-1:0] = '0;
`endif
    end

    // Frame counter, shift register and serial output stage. The load cycle
    // replaces the shift so packets follow each other without a gap; bit 0
    // reaches sdata one cycle after the load, when count is 0 again.
    // 'primed' keeps frame_start quiet during the first window after reset,
    // when the shift register still holds zeros rather than a packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            bx_cnt      <= '0;
            bx_loaded   <= '0;
            primed      <= 1'b0;
            shreg       <= '0;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
            bx_id       <= '0;
        end else begin
            count       <= count + 8'd1;
            sdata       <= shreg[0];
            frame_start <= primed && (count == 8'd0);
            if (primed && (count == 8'd0)) begin
                bx_id <= bx_loaded;
            end
            if (load) begin
                shreg     <= pkt;
                bx_loaded <= bx_cnt;
                bx_cnt    <= bx_cnt + BX_W'(1);
                primed    <= 1'b1;
            end else begin
                shreg <= {1'b0, shreg[PKT_W-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_cic_packet_tx.sv
// tb_cic_packet_tx: directed self-checking bench for cic_packet_tx.
// A negedge monitor deserialises every packet that starts with frame_start;
// the main sequence drives stubs and checks the captured packets.
// Trailer expectations follow CIC_TX_PARITY_EN when it is defined.
module tb_cic_packet_tx;
    import dtc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [20:0] stub_data;
    logic        stub_valid;
    logic        stub_ready;
    logic        sdata;
    logic        frame_start;
    logic [11:0] bx_id;

    int compCount = 0;
    int errCount  = 0;
    int cyc       = 0;

    logic [255:0] pkts   [16];
    int           fsCyc  [16];
    logic [11:0]  bxIdFs [16];
    int           pktCount  = 0;
    logic         capturing = 1'b0;
    int           bitIdx    = 0;
    logic [255:0] shiftPkt;

    logic [20:0]  expSlots [10];

    always #5 clk = ~clk;

    cic_packet_tx dut (
        .clk         (clk),
        .rst         (rst),
        .stub_data   (stub_data),
        .stub_valid  (stub_valid),
        .stub_ready  (stub_ready),
        .sdata       (sdata),
        .frame_start (frame_start),
        .bx_id       (bx_id)
    );

    // Cycles since reset release; the frame counter equals cyc % 256.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Serial deserialiser: restarts on frame_start, drops partial packets on reset.
    always @(negedge clk) begin
        if (rst) begin
            capturing = 1'b0;
        end else begin
            if (frame_start) begin
                capturing = 1'b1;
                bitIdx    = 0;
                fsCyc[pktCount % 16]  = cyc;
                bxIdFs[pktCount % 16] = bx_id;
            end
            if (capturing) begin
                shiftPkt[bitIdx] = sdata;
                bitIdx = bitIdx + 1;
                if (bitIdx == 256) begin
                    pkts[pktCount % 16] = shiftPkt;
                    pktCount  = pktCount + 1;
                    capturing = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compCount++;
        assert (obs === exp) else begin
            errCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("[TB] %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeoutFail(input string tag);
        compCount++;
        errCount++;
        $display("[TB] FAIL %s: observed timeout expected event", tag);
    endtask

    task automatic waitPkt(input int idx);
        int n = 0;
        while (pktCount <= idx && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (pktCount <= idx) timeoutFail($sformatf("waitPkt%0d", idx));
    endtask

    task automatic waitCount(input int c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((cyc % 256) != c && n < 600);
        if ((cyc % 256) != c) timeoutFail($sformatf("waitCount%0d", c));
    endtask

    // Offers one stub and returns at the negedge after it was accepted,
    // leaving stub_valid high so consecutive calls form a continuous stream.
    task automatic applyStimulus(input logic [20:0] d);
        int n = 0;
        stub_data  = d;
        stub_valid = 1'b1;
        while (!stub_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!stub_ready) timeoutFail("stubAccept");
        @(negedge clk);
    endtask

    function automatic logic [20:0] bpStub(input int i);
        return {3'(i), 3'(i + 1), 15'(i * 257)};
    endfunction

    task automatic fillExp();
        for (int k = 0; k < 10; k++) expSlots[k] = 21'h1FFFFF;
    endtask

    task automatic checkPacket(input string tag, input int idx, input logic [11:0] expBx,
                               input logic [3:0] expCnt, input int expBp);
        logic [255:0] p;
        logic [19:0]  expTrl;
        p = pkts[idx % 16];
        expTrl = '0;
`ifdef CIC_TX_PARITY_EN
        for (int k = 0; k < 10; k++) expTrl[k] = ^expSlots[k];
`endif
        checkOutput({tag, " sync"},     32'(p[255:248]), 32'h0000_00A5);
        checkOutput({tag, " bx"},       32'(p[247:236]), 32'(expBx));
        checkOutput({tag, " slotCnt"},  32'(p[235:232]), 32'(expCnt));
        if (expBp >= 0) checkOutput({tag, " bpFlag"}, 32'(p[231]), 32'(expBp));
        checkOutput({tag, " reserved"}, 32'(p[230]), 32'd0);
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("%s slot%0d", tag, k),
                        32'(p[229 - 21 * k -: 21]), 32'(expSlots[k]));
        end
        checkOutput({tag, " trailer"},  32'(p[19:0]), 32'(expTrl));
        checkOutput({tag, " bxIdOut"},  32'(bxIdFs[idx % 16]), 32'(expBx));
    endtask

    initial begin
        logic [255:0] p;
        rst        = 1'b1;
        stub_valid = 1'b0;
        stub_data  = '0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rstSdata",      32'(sdata),       32'd0);
        checkOutput("rstFrameStart", 32'(frame_start), 32'd0);
        checkOutput("rstReady",      32'(stub_ready),  32'd0);
        checkOutput("rstBxId",       32'(bx_id),       32'd0);
        rst = 1'b0;
        #1;
        checkOutput("readyAfterRst", 32'(stub_ready),  32'd1);

        // Idle packets 0 and 1; three stubs go into window 2 meanwhile
        waitPkt(0);
        fillExp();
        checkOutput("fsCycle0", 32'(fsCyc[0]), 32'd257);
        checkPacket("idle0", 0, 12'd0, 4'd0, 0);

        waitCount(5);
        applyStimulus(21'h0_8001);
        applyStimulus(21'h1_0002);
        applyStimulus(21'h1_FFFF);
        stub_valid = 1'b0;

        waitPkt(1);
        checkOutput("fsCycle1", 32'(fsCyc[1]), 32'd513);
        checkPacket("idle1", 1, 12'd1, 4'd0, 0);

        // Window 3: fifteen stubs back to back from count 0
        for (int i = 1; i <= 10; i++) applyStimulus(bpStub(i));
        checkOutput("readyAfter10", 32'(stub_ready), 32'd0);
        for (int i = 11; i <= 15; i++) applyStimulus(bpStub(i));
        stub_valid = 1'b0;

        waitPkt(2);
        fillExp();
        expSlots[0] = 21'h0_8001;
        expSlots[1] = 21'h1_0002;
        expSlots[2] = 21'h1_FFFF;
        checkPacket("three", 2, 12'd2, 4'd3, 0);
        p = pkts[2];
        checkOutput("chipId0", 32'(p[226:224]), 32'd1);
        checkOutput("chipId1", 32'(p[205:203]), 32'd2);

        waitPkt(3);
        for (int k = 0; k < 10; k++) expSlots[k] = bpStub(k + 1);
        checkPacket("bp10", 3, 12'd3, 4'd10, 1);

        // Window 5: stub offered exactly at count 255
        waitCount(255);
        stub_data  = 21'h00_0007;
        stub_valid = 1'b1;
        #1;
        checkOutput("readyAt255", 32'(stub_ready), 32'd0);
        @(negedge clk);
        checkOutput("readyAt0",   32'(stub_ready), 32'd1);
        @(negedge clk);
        stub_valid = 1'b0;

        waitPkt(4);
        fillExp();
        for (int k = 0; k < 5; k++) expSlots[k] = bpStub(k + 11);
        checkPacket("bp5", 4, 12'd4, 4'd5, 0);

        waitPkt(5);
        fillExp();
        checkPacket("edge", 5, 12'd5, 4'd0, -1);

        waitPkt(6);
        fillExp();
        expSlots[0] = 21'h00_0007;
        checkPacket("carry", 6, 12'd6, 4'd1, 0);
        p = pkts[6];
`ifdef CIC_TX_PARITY_EN
        checkOutput("parityTrailer", 32'(p[19:0]), 32'h0000_03FF);
`else
        checkOutput("parityTrailer", 32'(p[19:0]), 32'd0);
`endif

        // Reset in the middle of packet 7 (bit 99, inside the fill region)
        waitCount(100);
        checkOutput("preResetSdata", 32'(sdata), 32'd1);
        checkOutput("preResetBxId",  32'(bx_id), 32'd7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midRstSdata", 32'(sdata),       32'd0);
        checkOutput("midRstFs",    32'(frame_start), 32'd0);
        checkOutput("midRstReady", 32'(stub_ready),  32'd0);
        checkOutput("midRstBxId",  32'(bx_id),       32'd0);
        @(negedge clk);
        rst = 1'b0;

        waitPkt(7);
        fillExp();
        checkOutput("fsCycleAfterRst", 32'(fsCyc[7]), 32'd257);
        checkPacket("postRst", 7, 12'd0, 4'd0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
